// File: rtl/legv8_bus_arbiter.sv
// Two-master round-robin bus arbiter: IDLE -> ACCESS (WAIT_CYCLES+1) -> DONE.
// Optional ARB_LOCK_EN lets the owner chain a locked transaction without an IDLE gap.
module legv8_bus_arbiter #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [63:0] PERIPH_BASE = 64'h1000000000000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_write,
  input  logic        m1_write,
  input  logic [63:0] m0_addr,
  input  logic [63:0] m1_addr,
  input  logic [63:0] m0_wdata,
  input  logic [63:0] m1_wdata,
  input  logic        m0_lock,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [63:0] rdata,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic        bus_drive,
  input  logic [63:0] bus_rdata,
  output logic        bus_mem_write,
  output logic        bus_en_ram,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;

  logic winner;
  logic src;
  logic lock_go;
  logic in_access;

  // On a tie the master that was not granted most recently wins.
  always_comb begin
    if (m0_req && m1_req) winner = ~last_q;
    else                  winner = m1_req;
  end

`ifdef ARB_LOCK_EN
  assign lock_go = owner_q ? (m1_lock & m1_req) : (m0_lock & m0_req);
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
  assign lock_go     = 1'b0;
`endif

  // Capture source: the arbitration winner in IDLE, the current owner on a lock chain.
  assign src = (state_q == IDLE) ? winner : owner_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          owner_d = winner;
          last_d  = winner;
          write_d = src ? m1_write : m0_write;
          addr_d  = src ? m1_addr  : m0_addr;
          wdata_d = src ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          if (!write_q) rdata_d = bus_rdata;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        cnt_d = 4'd0;
        if (lock_go) begin
          state_d = ACCESS;
          write_d = src ? m1_write : m0_write;
          addr_d  = src ? m1_addr  : m0_addr;
          wdata_d = src ? m1_wdata : m0_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_access     = (state_q == ACCESS);
  assign busy          = (state_q != IDLE);
  assign m0_gnt        = busy & ~owner_q;
  assign m1_gnt        = busy &  owner_q;
  assign m0_done       = (state_q == DONE) & ~owner_q;
  assign m1_done       = (state_q == DONE) &  owner_q;
  assign rdata         = rdata_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign bus_mem_write = in_access & write_q;
  assign bus_drive     = in_access & write_q;
  assign bus_en_ram    = ~(in_access && (addr_q[63:12] == PERIPH_BASE[63:12]));

endmodule

// File: doc/legv8_bus_arbiter.md
LEGV8_BUS_ARBITER -- requirements
Module: legv8_bus_arbiter

Interface
- REQ-001: WAIT_CYCLES, default 1, number of extra ACCESS cycles per transaction (legal range 0..15).
- REQ-002: PERIPH_BASE, default 64'h1000000000000000, base address of the memory-mapped peripheral (GPIO) window; only bits [63:12] are compared.
- REQ-003: clock  input  1  single system clock; all state changes on its rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: m0_req, m1_req  input  1 each  transaction request (m0 = processor, m1 = secondary master); held high until done.
- REQ-006: m0_write, m1_write  input  1 each  1 = write, 0 = read; held stable while req is high.
- REQ-007: m0_addr, m1_addr  input  64 each  byte address; held stable while req is high.
- REQ-008: m0_wdata, m1_wdata  input  64 each  write data; held stable while req is high.
- REQ-009: m0_lock, m1_lock  input  1 each  request to keep the bus for the next transaction (see Configuration).
- REQ-010: m0_gnt, m1_gnt  output  1 each  master owns the bus (ACCESS and DONE).
- REQ-011: m0_done, m1_done  output  1 each  one-cycle completion pulse.
- REQ-012: rdata  output  64  read data captured for the current owner; valid while done is high.
- REQ-013: bus_addr  output  64  address to RAM/peripherals.
- REQ-014: bus_wdata  output  64  write data; bus_drive  output  1  top level enables the tri-state data driver when high.
- REQ-015: bus_rdata  input  64  resolved shared data bus.
- REQ-016: bus_mem_write  output  1  M_Write strobe; bus_en_ram  output  1  En_Ram (1 = RAM selected, 0 = peripheral window selected).
- REQ-017: busy  output  1  high in every state other than IDLE.

Function
- REQ-018: The FSM SHALL have the states IDLE, ACCESS and DONE.
- REQ-019: IDLE: if any req is high, pick the winner, latch its addr/write/wdata and go to ACCESS; otherwise stay in IDLE.
- REQ-020: Arbitration SHALL be round-robin: on a tie the master not granted most recently wins; a single requester wins immediately.
- REQ-021: ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, counted by a 4-bit counter; on the last cycle rdata <= bus_rdata for reads, then go to DONE.
- REQ-022: During ACCESS: bus_addr = latched address; bus_mem_write = bus_drive = latched write; bus_en_ram = 0 iff addr[63:12] == PERIPH_BASE[63:12].
- REQ-023: DONE SHALL last one cycle: the owner's done = 1, all bus strobes = 0, then go to IDLE; a new grant requires at least one IDLE cycle (no lock case).
- REQ-024: Latency: with req sampled high in IDLE at cycle 0, done SHALL be high in cycle WAIT_CYCLES+2 (cycle 3 at the default).
- REQ-025: Outside ACCESS: bus_mem_write = 0, bus_drive = 0, bus_en_ram = 1, and bus_addr/bus_wdata hold their last values.
- REQ-026: Deasserting req mid-transaction SHALL NOT abort it; done still pulses.
- REQ-027: A request from the non-owner SHALL be held off (gnt stays 0) until it wins a later IDLE arbitration; no request is lost.
- REQ-028: gnt SHALL be one-hot or zero at all times.

Reset
- REQ-029: Reset SHALL force IDLE, counter = 0, all gnt/done = 0, rdata = 0, bus_addr = 0, bus_wdata = 0, bus_drive = 0, bus_mem_write = 0, bus_en_ram = 1, busy = 0, and last-granted = m1, so m0 wins the first tie.
- REQ-030: Reset asserted mid-transaction SHALL abort it with no done pulse; reset has priority over every other event.

Configuration
- REQ-031: With ARB_LOCK_EN defined: if the owner's lock is high in DONE and its req is high, go directly to ACCESS for the same master, latch its new addr/write/wdata and keep its gnt high; last-granted is not updated.
- REQ-032: Without ARB_LOCK_EN: m0_lock and m1_lock SHALL be ignored, and every transaction returns to IDLE.

Verification
- REQ-033: m0 reads 64'h1000000000000200 alone, WAIT_CYCLES=1, bus_rdata=64'hA5 -> bus_en_ram=0 in cycles 1-2, m0_done in cycle 3, rdata=64'hA5.
- REQ-034: m0 and m1 both request writes from reset -> m0 is granted first; m1 is granted at the next IDLE; the following tie goes to m0; bus_mem_write is high only in ACCESS.
- REQ-035: m1 writes 64'h0000000000000040 with data 64'h1234 -> bus_en_ram=1, bus_wdata=64'h1234, bus_drive=1 for 2 cycles, m1_done=1 once.
- REQ-036: Reset asserted in the first ACCESS cycle -> no done, all outputs at their reset values on the next cycle, busy=0.
- REQ-037: With ARB_LOCK_EN, m0 issues a locked read followed by a write while m1 is requesting -> m0 gets 2 back-to-back transactions with no IDLE gap, then m1 is granted; without the macro, m1 is granted between them.
